apb_cmd_master: RTL and testbench
=================================

# apb_cmd_master

Single-outstanding APB master that sits directly upstream of the APB slave register banks. Accepts read/write commands on a valid/ready command port, decodes the target slave from address bits [9:8] (four 256-byte windows at 0x000, 0x100, 0x200, 0x300), runs the APB SETUP/ACCESS sequence and returns read data and status on a valid/ready response port. Routes the per-slave APB_RDATA/APB_READY back to the requester.

## Interface
- DATAWIDTH, 32: APB data width; also APB_ADDR width.
- ADDRWIDTH, 10: command address width; bits [9:8] select the slave, [7:0] are the in-window offset.
- NSLAVE, 4: number of slave selects (1..4).
- TIMEOUT, 16: maximum ACCESS cycles before abort (only with the timeout macro).
- APB_CLK  in  1  single clock, all logic on rising edge.
- APB_RESET  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  command accepted when VALID&READY.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_ADDR  in  ADDRWIDTH  byte address.
- CMD_WDATA  in  DATAWIDTH  write data.
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  response consumed when VALID&READY.
- RSP_RDATA  out  DATAWIDTH  read data (0 for writes and errors).
- RSP_ERR  out  1  1 = decode error or timeout.
- APB_SEL  out  NSLAVE  one-hot slave select.
- APB_ENABLE  out  1  ACCESS phase.
- APB_WRITE  out  1  transfer direction.
- APB_ADDR  out  DATAWIDTH  CMD_ADDR zero-extended.
- APB_WDATA  out  DATAWIDTH  write data.
- APB_RDATA  in  NSLAVE*DATAWIDTH  slave i read data at [i*DATAWIDTH +: DATAWIDTH].
- APB_READY  in  NSLAVE  per-slave ready.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: CMD_READY=1. On CMD_VALID, register WRITE/ADDR/WDATA. If ADDR[9:8] < NSLAVE, go to SETUP. Otherwise go straight to RESP with RSP_ERR=1 and RSP_RDATA=0; no APB_SEL bit toggles.
- SETUP: drive APB_SEL[ADDR[9:8]]=1, APB_ENABLE=0, and the registered ADDR/WRITE/WDATA. Always lasts exactly one cycle, then go to ACCESS.
- ACCESS: keep APB_SEL, set APB_ENABLE=1. On APB_READY[sel]=1:
  - capture APB_RDATA slice sel (reads; 0 for writes);
  - set RSP_ERR=0;
  - go to RESP.
  Otherwise stay in ACCESS.
- RESP: APB_SEL=0, APB_ENABLE=0, RSP_VALID=1. RSP_RDATA and RSP_ERR stay stable until RSP_READY. On RSP_READY go to IDLE.
- APB_ADDR/APB_WRITE/APB_WDATA hold their last value outside transfers.
- Only the selected slave's READY and RDATA are used. Other bits are ignored.
- Reset (async, any state): state to IDLE. All outputs go to 0, including CMD_READY=0 while reset is asserted. Any in-flight command is dropped with no response. APB_SEL/ENABLE deassert immediately.

## Timing
- CMD accepted at edge T. SETUP during T+1. ACCESS during T+2.
- With the slave's registered READY (asserted in the first ACCESS cycle), RSP_VALID rises at T+3.
- Minimum command-to-command spacing is 4 cycles: IDLE, SETUP, ACCESS, RESP with RSP_READY=1.
- Each extra cycle with READY low adds one ACCESS cycle.
- CMD_READY is 0 in SETUP, ACCESS and RESP. Commands are never queued.
- Decode error: RSP_VALID at T+1.

## Configuration
- APB_CMD_MASTER_TIMEOUT_EN defined:
  - A counter clears on SETUP entry and increments each ACCESS cycle.
  - If READY is still 0 in the TIMEOUT-th ACCESS cycle, go to RESP with RSP_ERR=1 and RSP_RDATA=0.
  - READY arriving in that same cycle wins: normal completion.
- Undefined: no counter. ACCESS waits indefinitely. RSP_ERR is set only by decode errors.

## Test plan
- Write then read slave 1: write 0x2A5A_5A5A to 0x104, then read 0x104 -> APB_SEL=4'b0010, SETUP then a single ACCESS; read returns RSP_RDATA=0x2A5A_5A5A, RSP_ERR=0, RSP_VALID 3 cycles after accept.
- Decode error: NSLAVE=2, read 0x300 -> APB_SEL stays 0, RSP_VALID next cycle, RSP_ERR=1, RSP_RDATA=0.
- Wait states: READY held low for 3 ACCESS cycles -> APB_SEL/ENABLE/ADDR stable throughout; response arrives 3 cycles later than the no-wait case.
- Timeout (macro on, TIMEOUT=16): READY never asserts -> exactly 16 ACCESS cycles, then RSP_ERR=1. Repeat with READY in the 16th cycle -> RSP_ERR=0.
- Backpressure: RSP_READY low for 5 cycles -> RSP_VALID/RDATA/ERR stable, CMD_READY=0; a pending CMD_VALID is accepted the cycle after the RESP handshake.
- Reset in ACCESS: assert APB_RESET mid-transfer -> APB_SEL/ENABLE/RSP_VALID go to 0 without a clock edge; after release, a fresh read of 0x004 completes normally.

Source files
------------

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB master: decodes slave from CMD_ADDR[9:8], runs SETUP/ACCESS, holds the response until taken.
// Optional ACCESS-phase timeout is enabled by defining APB_CMD_MASTER_TIMEOUT_EN.
module apb_cmd_master #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 10,
  parameter int NSLAVE    = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                        APB_CLK,
  input  logic                        APB_RESET,
  input  logic                        CMD_VALID,
  output logic                        CMD_READY,
  input  logic                        CMD_WRITE,
  input  logic [ADDRWIDTH-1:0]        CMD_ADDR,
  input  logic [DATAWIDTH-1:0]        CMD_WDATA,
  output logic                        RSP_VALID,
  input  logic                        RSP_READY,
  output logic [DATAWIDTH-1:0]        RSP_RDATA,
  output logic                        RSP_ERR,
  output logic [NSLAVE-1:0]           APB_SEL,
  output logic                        APB_ENABLE,
  output logic                        APB_WRITE,
  output logic [DATAWIDTH-1:0]        APB_ADDR,
  output logic [DATAWIDTH-1:0]        APB_WDATA,
  input  logic [NSLAVE*DATAWIDTH-1:0] APB_RDATA,
  input  logic [NSLAVE-1:0]           APB_READY
);

  if (NSLAVE < 1 || NSLAVE > 4 || TIMEOUT < 1 || ADDRWIDTH < 2) begin : g_param_check
    $error("apb_cmd_master: unsupported parameter combination");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t               state;
  logic [1:0]           sel_idx;
  logic [1:0]           cmd_idx;
  logic                 cmd_ok;
  logic                 sel_ready;
  logic [DATAWIDTH-1:0] sel_rdata;
  logic                 timed_out;

  assign cmd_idx = CMD_ADDR[ADDRWIDTH-1 -: 2];
  assign cmd_ok  = ({1'b0, cmd_idx} < 3'(NSLAVE));

  // Only the selected slave's READY/RDATA are looked at; all other lanes are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      if (sel_idx == 2'(i)) begin
        sel_ready = APB_READY[i];
        sel_rdata = APB_RDATA[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] acc_cnt;

  // acc_cnt holds k-1 during the k-th ACCESS cycle.
  assign timed_out = (acc_cnt == CW'(TIMEOUT - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge APB_CLK or posedge APB_RESET) begin
    if (APB_RESET) begin
      state      <= IDLE;
      sel_idx    <= '0;
      CMD_READY  <= 1'b0;
      RSP_VALID  <= 1'b0;
      RSP_RDATA  <= '0;
      RSP_ERR    <= 1'b0;
      APB_SEL    <= '0;
      APB_ENABLE <= 1'b0;
      APB_WRITE  <= 1'b0;
      APB_ADDR   <= '0;
      APB_WDATA  <= '0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
      acc_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          CMD_READY <= 1'b1;
          if (CMD_VALID && CMD_READY) begin
            CMD_READY <= 1'b0;
            if (cmd_ok) begin
              state     <= SETUP;
              sel_idx   <= cmd_idx;
              APB_SEL   <= NSLAVE'(1) << cmd_idx;
              APB_WRITE <= CMD_WRITE;
              APB_ADDR  <= DATAWIDTH'(CMD_ADDR);
              APB_WDATA <= CMD_WDATA;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
              acc_cnt   <= '0;
`endif
            end else begin
              // Unmapped window: answer immediately, the APB bus never moves.
              state     <= RESP;
              RSP_VALID <= 1'b1;
              RSP_ERR   <= 1'b1;
              RSP_RDATA <= '0;
            end
          end
        end

        SETUP: begin
          state      <= ACCESS;
          APB_ENABLE <= 1'b1;
        end

        ACCESS: begin
          if (sel_ready) begin
            state      <= RESP;
            APB_SEL    <= '0;
            APB_ENABLE <= 1'b0;
            RSP_VALID  <= 1'b1;
            RSP_ERR    <= 1'b0;
            RSP_RDATA  <= APB_WRITE ? '0 : sel_rdata;
          end else if (timed_out) begin
            state      <= RESP;
            APB_SEL    <= '0;
            APB_ENABLE <= 1'b0;
            RSP_VALID  <= 1'b1;
            RSP_ERR    <= 1'b1;
            RSP_RDATA  <= '0;
          end
`ifdef APB_CMD_MASTER_TIMEOUT_EN
          else begin
            acc_cnt <= acc_cnt + 1'b1;
          end
`endif
        end

        RESP: begin
          if (RSP_READY) begin
            state     <= IDLE;
            RSP_VALID <= 1'b0;
            CMD_READY <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with NSLAVE=2 and a two-slave APB memory model with programmable wait states.
module tb_apb_cmd_master;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NS = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [NS-1:0] apb_sel, apb_ready;
  logic          apb_enable, apb_write;
  logic [DW-1:0] apb_addr, apb_wdata;
  logic [NS*DW-1:0] apb_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int wait_n   = 0;
  int acc_cnt  = 0;
  logic [DW-1:0] mem [NS][64];

  apb_cmd_master #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .NSLAVE(NS), .TIMEOUT(TO)) dut (
    .APB_CLK(clk), .APB_RESET(rst),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write),
    .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
    .APB_SEL(apb_sel), .APB_ENABLE(apb_enable), .APB_WRITE(apb_write),
    .APB_ADDR(apb_addr), .APB_WDATA(apb_wdata), .APB_RDATA(apb_rdata), .APB_READY(apb_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Unselected slaves hold READY high and return their own data, which the master must ignore.
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      apb_rdata[i*DW +: DW] = mem[i][apb_addr[7:2]];
      apb_ready[i] = apb_sel[i] ? (apb_enable && (acc_cnt >= wait_n)) : 1'b1;
    end
  end

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int s = 0; s < NS; s++)
        for (int w = 0; w < 64; w++) mem[s][w] <= 32'hDEAD_0000 + DW'(s * 256 + w);
    end else if (apb_enable && (apb_sel != '0)) begin
      if (acc_cnt >= wait_n) begin
        for (int s = 0; s < NS; s++)
          if (apb_sel[s] && apb_write) mem[s][apb_addr[7:2]] <= apb_wdata;
      end else begin
        acc_cnt <= acc_cnt + 1;
      end
    end else begin
      acc_cnt <= 0;
    end
  end

  task automatic start_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output bit ok, output int t_acc);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    while (cmd_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    ok = (cmd_ready === 1'b1);
    t_acc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_access(input int t0, input logic [NS-1:0] esel, input logic [DW-1:0] eaddr,
                            output int lat, output int n_acc, output int bad);
    int n = 0;
    n_acc = 0; bad = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin
      if (apb_enable === 1'b1) begin
        n_acc++;
        if (apb_sel !== esel || apb_addr !== eaddr) bad++;
      end
      @(posedge clk); #1; n++;
    end
    lat = (rsp_valid === 1'b1) ? cyc - t0 : -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; wait_n = 0;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready got %b want 0", cmd_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (apb_sel !== 2'b00 || apb_enable !== 1'b0) $display("FAIL rst_apb got sel=%b en=%b want 00/0", apb_sel, apb_enable); else n_pass++;
    n_checks++; if (apb_addr !== 32'h0 || rsp_rdata !== 32'h0) $display("FAIL rst_data got addr=%h rdata=%h want 0/0", apb_addr, rsp_rdata); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", cmd_ready); else n_pass++;
  endtask

  task automatic test_write_read();
    bit ok; int t0, lat, na, bad;
    start_cmd(1'b1, 10'h104, 32'h2A5A_5A5A, ok, t0);
    n_checks++; if (!ok) $display("FAIL wr_accept got no CMD_READY want accept"); else n_pass++;
    n_checks++; if (apb_sel !== 2'b10 || apb_enable !== 1'b0) $display("FAIL wr_setup got sel=%b en=%b want 10/0", apb_sel, apb_enable); else n_pass++;
    n_checks++; if (apb_write !== 1'b1 || apb_addr !== 32'h104 || apb_wdata !== 32'h2A5A_5A5A)
      $display("FAIL wr_setup_bus got w=%b a=%h d=%h want 1/104/2a5a5a5a", apb_write, apb_addr, apb_wdata); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b0) $display("FAIL wr_setup_ready got %b want 0", cmd_ready); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (apb_sel !== 2'b10 || apb_enable !== 1'b1) $display("FAIL wr_access got sel=%b en=%b want 10/1", apb_sel, apb_enable); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0)
      $display("FAIL wr_rsp got v=%b e=%b d=%h want 1/0/0", rsp_valid, rsp_err, rsp_rdata); else n_pass++;
    n_checks++; if (apb_sel !== 2'b00 || apb_enable !== 1'b0 || apb_addr !== 32'h104)
      $display("FAIL wr_rsp_bus got sel=%b en=%b a=%h want 00/0/104", apb_sel, apb_enable, apb_addr); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL wr_done got v=%b rdy=%b want 0/1", rsp_valid, cmd_ready); else n_pass++;
    n_checks++; if (mem[1][1] !== 32'h2A5A_5A5A) $display("FAIL wr_slave_mem got %h want 2a5a5a5a", mem[1][1]); else n_pass++;
    start_cmd(1'b0, 10'h104, 32'h0, ok, t0);
    n_checks++; if (apb_write !== 1'b0 || apb_sel !== 2'b10) $display("FAIL rd_setup got w=%b sel=%b want 0/10", apb_write, apb_sel); else n_pass++;
    run_access(t0, 2'b10, 32'h104, lat, na, bad);
    n_checks++; if (lat !== 3 || na !== 1) $display("FAIL rd_latency got lat=%0d acc=%0d want 3/1", lat, na); else n_pass++;
    n_checks++; if (rsp_rdata !== 32'h2A5A_5A5A || rsp_err !== 1'b0) $display("FAIL rd_data got d=%h e=%b want 2a5a5a5a/0", rsp_rdata, rsp_err); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_decode_error();
    bit ok; int t0;
    start_cmd(1'b0, 10'h300, 32'h0, ok, t0);
    n_checks++; if (rsp_valid !== 1'b1 || (cyc - t0) !== 1) $display("FAIL dec_timing got v=%b lat=%0d want 1/1", rsp_valid, cyc - t0); else n_pass++;
    n_checks++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) $display("FAIL dec_rsp got e=%b d=%h want 1/0", rsp_err, rsp_rdata); else n_pass++;
    n_checks++; if (apb_sel !== 2'b00 || apb_enable !== 1'b0) $display("FAIL dec_bus got sel=%b en=%b want 00/0", apb_sel, apb_enable); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL dec_done got v=%b rdy=%b want 0/1", rsp_valid, cmd_ready); else n_pass++;
  endtask

  task automatic test_wait_states();
    bit ok; int t0, lat, na, bad;
    wait_n = 3;
    start_cmd(1'b0, 10'h104, 32'h0, ok, t0);
    run_access(t0, 2'b10, 32'h104, lat, na, bad);
    n_checks++; if (lat !== 6 || na !== 4) $display("FAIL ws_latency got lat=%0d acc=%0d want 6/4", lat, na); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL ws_stable got %0d unstable cycles want 0", bad); else n_pass++;
    n_checks++; if (rsp_rdata !== 32'h2A5A_5A5A || rsp_err !== 1'b0) $display("FAIL ws_data got d=%h e=%b want 2a5a5a5a/0", rsp_rdata, rsp_err); else n_pass++;
    @(posedge clk); #1;
    wait_n = 0;
  endtask

  task automatic test_timeout();
    bit ok; int t0, lat, na, bad;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    wait_n = 1000;
    start_cmd(1'b0, 10'h104, 32'h0, ok, t0);
    run_access(t0, 2'b10, 32'h104, lat, na, bad);
    n_checks++; if (na !== TO || lat !== TO + 2) $display("FAIL to_cycles got acc=%0d lat=%0d want %0d/%0d", na, lat, TO, TO + 2); else n_pass++;
    n_checks++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) $display("FAIL to_rsp got e=%b d=%h want 1/0", rsp_err, rsp_rdata); else n_pass++;
    @(posedge clk); #1;
    wait_n = TO - 1;
    start_cmd(1'b0, 10'h104, 32'h0, ok, t0);
    run_access(t0, 2'b10, 32'h104, lat, na, bad);
    n_checks++; if (na !== TO) $display("FAIL to_last_cycle_acc got %0d want %0d", na, TO); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h2A5A_5A5A) $display("FAIL to_last_cycle_rsp got e=%b d=%h want 0/2a5a5a5a", rsp_err, rsp_rdata); else n_pass++;
`else
    wait_n = 20;
    start_cmd(1'b0, 10'h104, 32'h0, ok, t0);
    run_access(t0, 2'b10, 32'h104, lat, na, bad);
    n_checks++; if (na !== 21 || lat !== 23) $display("FAIL long_wait got acc=%0d lat=%0d want 21/23", na, lat); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h2A5A_5A5A) $display("FAIL long_wait_rsp got e=%b d=%h want 0/2a5a5a5a", rsp_err, rsp_rdata); else n_pass++;
`endif
    @(posedge clk); #1;
    wait_n = 0;
  endtask

  task automatic test_backpressure();
    bit ok; int t0, lat, na, bad;
    rsp_ready = 1'b0;
    start_cmd(1'b0, 10'h104, 32'h0, ok, t0);
    run_access(t0, 2'b10, 32'h104, lat, na, bad);
    n_checks++; if (lat !== 3) $display("FAIL bp_latency got %0d want 3", lat); else n_pass++;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h004; cmd_wdata = 32'hC3C3_0001;
    bad = 0;
    repeat (5) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h2A5A_5A5A || rsp_err !== 1'b0 || cmd_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    n_checks++; if (bad !== 0) $display("FAIL bp_hold got %0d bad cycles want 0", bad); else n_pass++;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || apb_sel !== 2'b00)
      $display("FAIL bp_handshake got v=%b rdy=%b sel=%b want 0/1/00", rsp_valid, cmd_ready, apb_sel); else n_pass++;
    t0 = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_checks++; if (apb_sel !== 2'b01 || apb_write !== 1'b1 || apb_addr !== 32'h004)
      $display("FAIL bp_next_accept got sel=%b w=%b a=%h want 01/1/004", apb_sel, apb_write, apb_addr); else n_pass++;
    run_access(t0, 2'b01, 32'h004, lat, na, bad);
    n_checks++; if (lat !== 3 || rsp_err !== 1'b0) $display("FAIL bp_next_rsp got lat=%0d e=%b want 3/0", lat, rsp_err); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_access();
    bit ok; int t0, lat, na, bad;
    wait_n = 1000;
    start_cmd(1'b0, 10'h104, 32'h0, ok, t0);
    @(posedge clk); #1; @(posedge clk); #1;
    n_checks++; if (apb_enable !== 1'b1) $display("FAIL ra_in_access got en=%b want 1", apb_enable); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (apb_sel !== 2'b00 || apb_enable !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0)
      $display("FAIL ra_async got sel=%b en=%b v=%b rdy=%b want 00/0/0/0", apb_sel, apb_enable, rsp_valid, cmd_ready); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0; wait_n = 0;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL ra_dropped got v=%b want 0", rsp_valid); else n_pass++;
    start_cmd(1'b0, 10'h004, 32'h0, ok, t0);
    n_checks++; if (!ok || apb_sel !== 2'b01) $display("FAIL ra_new_accept got ok=%b sel=%b want 1/01", ok, apb_sel); else n_pass++;
    run_access(t0, 2'b01, 32'h004, lat, na, bad);
    n_checks++; if (lat !== 3 || rsp_rdata !== 32'hC3C3_0001 || rsp_err !== 1'b0)
      $display("FAIL ra_new_rsp got lat=%0d d=%h e=%b want 3/c3c30001/0", lat, rsp_rdata, rsp_err); else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_decode_error();
    test_wait_states();
    test_timeout();
    test_backpressure();
    test_reset_in_access();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
